// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Multi-channel interrupt controller in front of the MCU control unit.
// Synchronises up to 8 asynchronous request lines and applies a per-channel
// mask and edge/level mode. Eligible requests are arbitrated by fixed priority
// (bit 0 highest). One registered INTR request goes to the control unit, and
// the winning channel index is held for the ISR.
//
// Register map (port I/O bus, BASE_ID..BASE_ID+3):
//   +0 MASK     R/W  1 = channel enabled
//   +1 MODE     R/W  1 = rising-edge, 0 = level
//   +2 PENDING  R    level bits follow the synchronised line;
//                    edge bits are latched, write 1 to clear
//   +3 VECTOR   R    {busy, in_service, 3'b0, ACTIVE_CH}; any write = EOI
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset, clears all state
//   IRQ_IN     asynchronous request lines (NUM_CH bits)
//   PORT_ID    I/O address from the MCU
//   OUT_PORT   write data from the MCU
//   IO_STRB    one-cycle write strobe
//   INTR_ACK   one-cycle pulse when the control unit enters the interrupt cycle
//   RD_DATA    combinational read data (0 when RD_HIT is low)
//   RD_HIT     PORT_ID decodes to one of the four registers
//   INTR       registered interrupt request
//   ACTIVE_CH  registered index of the requested / in-service channel
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int         NUM_CH      = 8,
  parameter logic [7:0] BASE_ID     = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] IRQ_IN,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        OUT_PORT,
  input  logic              IO_STRB,
  input  logic              INTR_ACK,
  output logic [7:0]        RD_DATA,
  output logic              RD_HIT,
  output logic              INTR,
  output logic [2:0]        ACTIVE_CH
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                             state;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  irq_s, irq_d, irq_rise;
  logic [NUM_CH-1:0]                  mask, mode, pend_edge;
  logic [NUM_CH-1:0]                  pending, eligible;
  logic [NUM_CH-1:0]                  mask_nxt, mode_nxt, pend_clr, pend_nxt;
  logic [7:0]                         offs;
  logic [1:0]                         reg_sel;
  logic                               wr_en, ack_take, eoi, any_elig;
  logic [7:0]                         ack8, elig8, mask8, mode8, pend8;
  logic [2:0]                         winner;

  // ---- synchroniser outputs and edge detect ----
  assign irq_s    = sync_q[SYNC_STAGES-1];
  assign irq_rise = irq_s & ~irq_d;

  // ---- address decode (8-bit wrap keeps the window contiguous) ----
  assign offs    = PORT_ID - BASE_ID;
  assign RD_HIT  = (offs[7:2] == 6'd0);
  assign reg_sel = offs[1:0];
  assign wr_en   = IO_STRB & RD_HIT;
  assign eoi     = wr_en && (reg_sel == 2'd3);

  assign ack_take = (state == REQ) && INTR_ACK;
  assign ack8     = ack_take ? (8'b1 << ACTIVE_CH) : 8'd0;

  assign mask_nxt = (wr_en && reg_sel == 2'd0) ? OUT_PORT[NUM_CH-1:0] : mask;
  assign mode_nxt = (wr_en && reg_sel == 2'd1) ? OUT_PORT[NUM_CH-1:0] : mode;
  assign pend_clr = ((wr_en && reg_sel == 2'd2) ? OUT_PORT[NUM_CH-1:0] : '0)
                    | ack8[NUM_CH-1:0];
  // A new edge wins over a same-cycle clear; gating with the next MODE drops
  // the latch of any channel that is being switched to level.
  assign pend_nxt = mode_nxt & (irq_rise | (pend_edge & ~pend_clr));

  assign pending  = (mode & pend_edge) | (~mode & irq_s);
  assign eligible = pending & mask;
  assign any_elig = |eligible;

  // Lowest eligible index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    elig8 = '0;
    mask8 = '0;
    mode8 = '0;
    pend8 = '0;
    elig8[NUM_CH-1:0] = eligible;
    mask8[NUM_CH-1:0] = mask;
    mode8[NUM_CH-1:0] = mode;
    pend8[NUM_CH-1:0] = pending;
    RD_DATA = 8'd0;
    if (RD_HIT) begin
      case (reg_sel)
        2'd0:    RD_DATA = mask8;
        2'd1:    RD_DATA = mode8;
        2'd2:    RD_DATA = pend8;
        default: RD_DATA = {(state != IDLE), (state == SERVICE), 3'b000, ACTIVE_CH};
      endcase
    end
  end

  // ---- register stage: synchroniser, configuration, latched edges ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q    <= '0;
      irq_d     <= '0;
      mask      <= '0;
      mode      <= '0;
      pend_edge <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
      irq_d     <= irq_s;
      mask      <= mask_nxt;
      mode      <= mode_nxt;
      pend_edge <= pend_nxt;
    end
  end

  // ---- request / service FSM with registered outputs ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      INTR      <= 1'b0;
      ACTIVE_CH <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            ACTIVE_CH <= winner;
            INTR      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Priority is locked here: ACTIVE_CH is not re-evaluated.
          if (INTR_ACK) begin
            INTR  <= 1'b0;
            state <= SERVICE;
          end else if (!elig8[ACTIVE_CH]) begin
            INTR  <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          INTR <= 1'b0;
          if (eoi) state <= IDLE;
        end
        default: begin
          INTR  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
